core_irq_ctrl: RTL and testbench

//  Interrupt front-end directly upstream of core_top: registers external request lines,

---
 rtl/core_pkg.sv | 16 +
 rtl/irq_prio_enc.sv | 28 ++
 rtl/core_irq_ctrl.sv | 155 +++++++++++++++
 tb/tb_core_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core front-end blocks.
//   CORE_NUM_IRQ : default number of external interrupt request lines
//   IRQ_IDLE / IRQ_PULSE / IRQ_WAIT : 2-bit state encoding of the
//                                      interrupt dispatch FSM
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int CORE_NUM_IRQ = 4;

  localparam logic [1:0] IRQ_IDLE  = 2'd0;
  localparam logic [1:0] IRQ_PULSE = 2'd1;
  localparam logic [1:0] IRQ_WAIT  = 2'd2;

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder: the lowest set bit wins.
//   i_vec : request vector (NUM_IRQ bits)
//   o_id  : index of the lowest set bit (0 when nothing is set)
//   o_vld : 1 when any bit of i_vec is set
// -----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int NUM_IRQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_IRQ-1:0]  i_vec,
  output logic [ID_WIDTH-1:0] o_id,
  output logic                o_vld
);

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    o_id  = '0;
    o_vld = |i_vec;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_id = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/core_irq_ctrl.sv
// -----------------------------------------------------------------------------
// core_irq_ctrl
// Interrupt front-end for core_top. Captures rising edges on the request
// lines into pending bits, picks the lowest-index enabled pending line and
// hands it to the core as a one-cycle pulse while the sequencer is idle and
// the core is running, then waits for the core's acknowledge.
//   clk, reset   : core clock, asynchronous active-high reset
//   irq_req      : level request lines
//   irq_mask     : 1 = line may be dispatched (capture is never masked)
//   ps_idle      : program sequencer idle
//   stallb_en    : 1 = core running, 0 = stalled
//   ps_irq_ack   : acknowledge of the dispatched interrupt
//   irq_err_clr  : clears the sticky ack-timeout flag
//   interrupt    : one-cycle pulse into core_top
//   irq_id       : dispatched line index, held from pulse to ack
//   irq_pending  : pending bits
//   irq_busy     : handshake in progress
//   irq_err      : sticky ack-timeout flag
// -----------------------------------------------------------------------------
module core_irq_ctrl
  import core_pkg::*;
#(
  parameter int NUM_IRQ       = CORE_NUM_IRQ,
  parameter int ID_WIDTH      = 2,
  parameter int TIMEOUT_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_req,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                ps_idle,
  input  logic                stallb_en,
  input  logic                ps_irq_ack,
  input  logic                irq_err_clr,
  output logic                interrupt,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic [NUM_IRQ-1:0]  irq_pending,
  output logic                irq_busy,
  output logic                irq_err
);

  localparam logic [TIMEOUT_WIDTH-1:0] TO_MAX = '1;

  logic [NUM_IRQ-1:0]       r_req_q;
  logic                     r_armed;
  logic [NUM_IRQ-1:0]       r_pending;
  logic [1:0]               r_state;
  logic [ID_WIDTH-1:0]      r_id;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_err;

  logic [NUM_IRQ-1:0]       w_rise;
  logic [NUM_IRQ-1:0]       w_ack_clr;
  logic [ID_WIDTH-1:0]      w_disp_id;
  logic                     w_disp_vld;
  logic                     w_ack;
  logic                     w_timeout;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_inc;

  // Edge detect. r_armed stays low for the first clock after reset so that
  // lines already high when reset releases are absorbed into r_req_q rather
  // than seen as fresh edges; they must fall and rise again to be captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_q <= '0;
      r_armed <= 1'b0;
    end else begin
      r_req_q <= irq_req;
      r_armed <= 1'b1;
    end
  end

  assign w_rise = irq_req & ~r_req_q & {NUM_IRQ{r_armed}};

  irq_prio_enc #(
    .NUM_IRQ  (NUM_IRQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio (
    .i_vec (r_pending & irq_mask),
    .o_id  (w_disp_id),
    .o_vld (w_disp_vld)
  );

  assign w_ack     = (r_state == IRQ_WAIT) && ps_irq_ack;
  assign w_cnt_inc = r_cnt + 1'b1;
  // Only running cycles advance toward a timeout; an ack in the same cycle wins.
  assign w_timeout = (r_state == IRQ_WAIT) && !ps_irq_ack && stallb_en &&
                     (w_cnt_inc == TO_MAX);

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_ack_clr[i] = w_ack && (r_id == ID_WIDTH'(i));
    end
  end

  // A new edge in the same cycle as the ack re-arms the line (set wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_clr) | w_rise;
    end
  end

  // PULSE waits for a running core, so the pulse itself is never issued while
  // stalled and the core sees exactly one cycle of interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IRQ_IDLE;
      r_id    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_disp_vld && ps_idle && stallb_en) begin
            r_state <= IRQ_PULSE;
            r_id    <= w_disp_id;
          end
        end
        IRQ_PULSE: begin
          if (stallb_en) begin
            r_state <= IRQ_WAIT;
            r_cnt   <= '0;
          end
        end
        IRQ_WAIT: begin
          if (w_ack || w_timeout) begin
            r_state <= IRQ_IDLE;
          end else if (stallb_en) begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IRQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (irq_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign interrupt   = (r_state == IRQ_PULSE) && stallb_en;
  assign irq_id      = r_id;
  assign irq_pending = r_pending;
  assign irq_busy    = (r_state != IRQ_IDLE);
  assign irq_err     = r_err;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_irq_ctrl
// Self-checking bench for core_irq_ctrl (NUM_IRQ=4, TIMEOUT_WIDTH=4).
// A behavioural model tracks pending requests, the outstanding dispatch and
// the remaining ack budget; directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_core_irq_ctrl;

  localparam int N      = 4;
  localparam int TO_CYC = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] d_req = '0, d_mask = '0;
  logic         d_idle = 1'b0, d_stb = 1'b0, d_ack = 1'b0, d_clr = 1'b0;

  logic         interrupt;
  logic [1:0]   irq_id;
  logic [N-1:0] irq_pending;
  logic         irq_busy, irq_err;

  int n_tests = 0;
  int n_fail  = 0;

  core_irq_ctrl #(.NUM_IRQ(N), .ID_WIDTH(2), .TIMEOUT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (rst),
    .irq_req     (d_req),
    .irq_mask    (d_mask),
    .ps_idle     (d_idle),
    .stallb_en   (d_stb),
    .ps_irq_ack  (d_ack),
    .irq_err_clr (d_clr),
    .interrupt   (interrupt),
    .irq_id      (irq_id),
    .irq_pending (irq_pending),
    .irq_busy    (irq_busy),
    .irq_err     (irq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_pend [N];
  bit         m_prev [N];
  bit         m_armed;
  bit         m_pulse_due;   // chosen line not yet handed to the core
  bit         m_waiting;     // handed over, ack outstanding
  int         m_left;        // running cycles left before giving up on the ack
  int         m_id;
  bit         m_err;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_armed = 0; m_pulse_due = 0; m_waiting = 0; m_left = 0; m_id = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit np [N];
    bit gave_up;
    int sel;
    if (rst) begin
      model_reset();
      return;
    end
    gave_up = 0;
    for (int i = 0; i < N; i++) np[i] = m_pend[i];
    if (m_pulse_due) begin
      if (d_stb) begin
        m_pulse_due = 0;
        m_waiting   = 1;
        m_left      = TO_CYC;
      end
    end else if (m_waiting) begin
      if (d_ack) begin
        np[m_id]  = 0;
        m_waiting = 0;
      end else if (d_stb) begin
        m_left--;
        if (m_left == 0) begin
          gave_up   = 1;
          m_waiting = 0;
        end
      end
    end else begin
      sel = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && d_mask[i]) sel = i;
      if (sel >= 0 && d_idle && d_stb) begin
        m_id        = sel;
        m_pulse_due = 1;
      end
    end
    if (gave_up) m_err = 1;
    else if (d_clr) m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = np[i] | (m_armed && d_req[i] && !m_prev[i]);
      m_prev[i] = d_req[i];
    end
    m_armed = 1;
  endtask

  task automatic compare(input string pre);
    logic [N-1:0] ep;
    for (int i = 0; i < N; i++) ep[i] = m_pend[i];
    chk({pre, "_int"},  32'(interrupt),   32'(m_pulse_due && d_stb));
    chk({pre, "_id"},   32'(irq_id),      32'(m_id));
    chk({pre, "_pend"}, 32'(irq_pending), 32'(ep));
    chk({pre, "_busy"}, 32'(irq_busy),    32'(m_pulse_due || m_waiting));
    chk({pre, "_err"},  32'(irq_err),     32'(m_err));
  endtask

  // ---------------- cycle driver ----------------
  bit obs_int, prev_obs_int;
  int n_pulses, n_stalled_pulses, n_b2b;

  // Inputs are set at edge+1; outputs are checked at edge+3, before the next edge.
  task automatic tick();
    #2;
    compare("cyc");
    prev_obs_int = obs_int;
    obs_int      = interrupt;
    if (obs_int) n_pulses++;
    if (obs_int && !d_stb) n_stalled_pulses++;
    if (obs_int && prev_obs_int) n_b2b++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_int(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (obs_int) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic ack_once();
    d_ack = 1; tick(); d_ack = 0;
  endtask

  int n, cnt, k0;

  initial begin
    model_reset();
    #1 rst = 1;
    #1 compare("reset");
    repeat (3) tick();
    rst = 0;
    d_mask = 4'hF; d_idle = 1; d_stb = 1;
    repeat (4) tick();

    // 1: single request, two-cycle latency, ack clears pending
    d_req[2] = 1; tick();
    wait_int(10, n);
    chk("t1_latency", n, 2);
    chk("t1_id", irq_id, 2);
    tick(); tick();
    ack_once(); d_req[2] = 0;
    chk("t1_pend_clr", irq_pending, 0);
    tick(); tick();

    // 2: simultaneous edges, lowest index first, no back-to-back redispatch
    d_req = 4'b1010; tick();
    wait_int(10, n);
    chk("t2_first_id", irq_id, 1);
    tick(); ack_once();
    wait_int(10, n);
    chk("t2_gap_ok", 32'(n >= 2), 1);
    chk("t2_second_id", irq_id, 3);
    ack_once(); d_req = 0; tick();

    // 3: gating by ps_idle, then stall toggling
    d_idle = 0; d_req[0] = 1; tick();
    k0 = n_pulses;
    repeat (20) tick();
    chk("t3_idle_hold", n_pulses - k0, 0);
    d_idle = 1;
    k0 = n_pulses;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 41; c++) begin
        d_stb = (c < 9);
        d_ack = obs_int;
        if (c % 5 == 0) d_req[0] = ~d_req[0];
        tick();
      end
    end
    d_ack = 0; d_stb = 1; d_req = 0;
    repeat (20) begin d_ack = obs_int; tick(); end
    d_ack = 0;
    chk("t3_pulses_seen", 32'(n_pulses > k0), 1);
    chk("t3_stalled_pulses", n_stalled_pulses, 0);
    chk("t3_back_to_back", n_b2b, 0);
    tick(); tick();

    // 4: ack timeout, sticky error, redispatch, clear
    d_req[1] = 1; tick();
    wait_int(10, n);
    chk("t4_id", irq_id, 1);
    cnt = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (irq_err) begin cnt = k; break; end
    end
    chk("t4_to_cycles", cnt, TO_CYC);
    wait_int(5, n);
    chk("t4_redispatch", 32'(n > 0), 1);
    chk("t4_redispatch_id", irq_id, 1);
    d_clr = 1; tick(); d_clr = 0;
    chk("t4_err_clr", irq_err, 0);
    ack_once(); d_req = 0; tick(); tick();

    // 5: masked capture, dispatch on unmask
    d_mask = 4'b1110; d_req[0] = 1; tick(); d_req[0] = 0;
    k0 = n_pulses;
    repeat (5) tick();
    chk("t5_masked_pend", irq_pending[0], 1);
    chk("t5_masked_quiet", n_pulses - k0, 0);
    d_mask = 4'hF;
    wait_int(4, n);
    chk("t5_unmask", 32'(n >= 1 && n <= 2), 1);
    chk("t5_id", irq_id, 0);
    ack_once(); tick();

    // 6: async reset mid-handshake; held line not recaptured
    d_req[3] = 1; tick();
    wait_int(10, n);
    tick();
    #1 rst = 1; model_reset();
    #1 compare("t6_async_rst");
    tick(); rst = 0;
    k0 = n_pulses;
    repeat (6) tick();
    chk("t6_no_recapture", irq_pending, 0);
    chk("t6_quiet", n_pulses - k0, 0);
    d_req[3] = 0; tick(); d_req[3] = 1; tick();
    wait_int(5, n);
    chk("t6_new_edge_id", 32'(n > 0 ? irq_id : 4), 3);
    ack_once(); d_req = 0; tick();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) d_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) d_mask = 4'($urandom_range(0, 15));
      d_idle = ($urandom_range(0, 3) != 0);
      d_stb  = ($urandom_range(0, 4) != 0);
      d_ack  = ($urandom_range(0, 2) == 0);
      d_clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1; model_reset();
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end
    chk("rnd_no_b2b", n_b2b, 0);
    chk("rnd_no_stalled", n_stalled_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
